// File: rtl/dram_arb.sv
// -----------------------------------------------------------------------------
// dram_arb
// Two-requester arbiter for the single data-RAM port.
//   m0 : CPU data port (fixed high priority)
//   m1 : UART debug/loader path (live memory access while the CPU runs)
// m1 is guaranteed a slot after STARVE_MAX consecutive blocked cycles. The
// owner of each outstanding read is tracked for one cycle so the RAM read
// data can be flagged valid to the requester that issued it.
//
// Ports
//   clk_i, rst_n_i              clock, synchronous active-low reset
//   mX_req_i / mX_we_i          request, 1=write 0=read (X = 0,1)
//   mX_addr_i / mX_wr_data_i    byte address, write data
//   mX_byte_en_i                write byte lanes
//   mX_gnt_o                    request accepted this cycle (combinational)
//   mX_rd_data_o / mX_rd_vld_o  read data and its valid flag
//   ram_en_o / ram_we_o         RAM enable, byte write enables (0 on read)
//   ram_addr_o / ram_wr_data_o  RAM address, write data
//   ram_rd_data_i               RAM read data, one cycle after ram_en_o
// -----------------------------------------------------------------------------
module dram_arb #(
    parameter int XLEN       = 32,
    parameter int STARVE_MAX = 8
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            m0_req_i,
    input  logic            m0_we_i,
    input  logic [XLEN-1:0] m0_addr_i,
    input  logic [XLEN-1:0] m0_wr_data_i,
    input  logic [3:0]      m0_byte_en_i,
    output logic            m0_gnt_o,
    output logic [XLEN-1:0] m0_rd_data_o,
    output logic            m0_rd_vld_o,
    input  logic            m1_req_i,
    input  logic            m1_we_i,
    input  logic [XLEN-1:0] m1_addr_i,
    input  logic [XLEN-1:0] m1_wr_data_i,
    input  logic [3:0]      m1_byte_en_i,
    output logic            m1_gnt_o,
    output logic [XLEN-1:0] m1_rd_data_o,
    output logic            m1_rd_vld_o,
    output logic            ram_en_o,
    output logic [3:0]      ram_we_o,
    output logic [XLEN-1:0] ram_addr_o,
    output logic [XLEN-1:0] ram_wr_data_o,
    input  logic [XLEN-1:0] ram_rd_data_i
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_M0   = 2'd1,
        OWN_M1   = 2'd2
    } owner_t;

    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    logic [7:0] starve_cnt;
    owner_t     rd_owner_p1;

    logic       gnt0;
    logic       gnt1;
    logic       sel_we;
    logic [3:0] sel_be;

    // ---- stage p0: combinational arbitration and RAM mux --------------------
    always_comb begin
        // m1 wins when the guard has expired or when m0 is idle; reset blocks all.
        gnt1   = rst_n_i && m1_req_i && ((starve_cnt == STARVE_LIM) || !m0_req_i);
        gnt0   = rst_n_i && m0_req_i && !gnt1;
        sel_we = gnt1 ? m1_we_i : m0_we_i;
        sel_be = gnt1 ? m1_byte_en_i : m0_byte_en_i;

        ram_en_o      = gnt0 || gnt1;
        ram_we_o      = (ram_en_o && sel_we) ? sel_be : 4'b0000;
        ram_addr_o    = gnt1 ? m1_addr_i : m0_addr_i;
        ram_wr_data_o = gnt1 ? m1_wr_data_i : m0_wr_data_i;
    end

    assign m0_gnt_o = gnt0;
    assign m1_gnt_o = gnt1;

    // ---- stage p0 -> p1: starvation counter and read-owner tracking ---------
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            starve_cnt  <= 8'd0;
            rd_owner_p1 <= OWN_NONE;
        end else begin
            // Any cycle where m1 is served or stops asking ends the window.
            if (gnt1 || !m1_req_i) begin
                starve_cnt <= 8'd0;
            end else if (starve_cnt != STARVE_LIM) begin
                starve_cnt <= starve_cnt + 8'd1;
            end

            if (gnt0 && !m0_we_i) begin
                rd_owner_p1 <= OWN_M0;
            end else if (gnt1 && !m1_we_i) begin
                rd_owner_p1 <= OWN_M1;
            end else begin
                rd_owner_p1 <= OWN_NONE;
            end
        end
    end

    // ---- stage p1: read response -------------------------------------------
    // Gating with rst_n_i drops a response whose read was granted just before
    // reset asserted.
    assign m0_rd_vld_o  = rst_n_i && (rd_owner_p1 == OWN_M0);
    assign m1_rd_vld_o  = rst_n_i && (rd_owner_p1 == OWN_M1);
    assign m0_rd_data_o = ram_rd_data_i;
    assign m1_rd_data_o = ram_rd_data_i;

endmodule
